// File: rtl/sfsm_pkg.sv
// Shared definitions for the SFSM serial link: frame geometry and receiver states.
package sfsm_pkg;

   localparam int SFSM_FRAME_BITS = 33;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DRAIN = 2'd2
   } rx_state_t;

endpackage

// File: rtl/sfsm_frame_rx_if.sv
// Parallel frame handoff from the SFSM receiver to its consumer (valid/ready).
interface sfsm_frame_rx_if
   import sfsm_pkg::*;
#(
   parameter int FRAME_BITS = SFSM_FRAME_BITS
);

   logic [FRAME_BITS-1:0] frame_data;
   logic                  frame_valid;
   logic                  frame_ready;

   modport master (output frame_data, output frame_valid, input frame_ready);
   modport slave  (input frame_data, input frame_valid, output frame_ready);

endinterface

// File: rtl/sfsm_rx_shifter.sv
// Serial-to-parallel shift register with a saturating-by-construction bit counter.
module sfsm_rx_shifter
   import sfsm_pkg::*;
#(
   parameter int FRAME_BITS = SFSM_FRAME_BITS,
   parameter int CNT_W      = 6
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  shift_en,
   input  logic                  din,
   output logic [FRAME_BITS-1:0] data,
   output logic [CNT_W-1:0]      count
);

   // clear together with shift_en starts a new frame: bit 0 lands and the count becomes 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data  <= '0;
         count <= '0;
      end else if (shift_en) begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // samples the pre-edge values, independent of statement order.
         data  <= clear ? {{(FRAME_BITS-1){1'b0}}, din} : {data[FRAME_BITS-2:0], din};
         count <= clear ? CNT_W'(1) : count + CNT_W'(1);
      end else if (clear) begin
         data  <= '0;
         count <= '0;
      end
   end

endmodule

// File: rtl/sfsm_frame_rx.sv
// SFSM link receiver: frames the cs/dout stream, checks length, buffers one frame.
module sfsm_frame_rx
   import sfsm_pkg::*;
#(
   parameter int FRAME_BITS = SFSM_FRAME_BITS,
   parameter int CNT_W      = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cs,
   input  logic             dout,
   sfsm_frame_rx_if.master  rx,
   output logic             err_short,
   output logic             err_long,
   output logic             err_overrun,
   output logic [7:0]       frame_count
);

   rx_state_t             state;
   logic                  clear;
   logic                  shift_en;
   logic [FRAME_BITS-1:0] sh_data;
   logic [CNT_W-1:0]      sh_count;
   logic                  full_len;

   assign full_len = (sh_count == CNT_W'(FRAME_BITS));

   sfsm_rx_shifter #(
      .FRAME_BITS (FRAME_BITS),
      .CNT_W      (CNT_W)
   ) u_shifter (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .shift_en (shift_en),
      .din      (dout),
      .data     (sh_data),
      .count    (sh_count)
   );

   // Shifter is held cleared whenever it is not collecting a frame.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      clear    = 1'b1;
      shift_en = 1'b0;
      case (state)
         IDLE:    shift_en = cs;
         SHIFT: begin
            shift_en = cs && !full_len;
            clear    = !(cs && !full_len);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         rx.frame_data  <= '0;
         rx.frame_valid <= 1'b0;
         err_short      <= 1'b0;
         err_long       <= 1'b0;
         err_overrun    <= 1'b0;
         frame_count    <= '0;
      end else begin
         err_short   <= 1'b0;
         err_long    <= 1'b0;
         err_overrun <= 1'b0;
         // NOTE: a later non-blocking assignment to frame_valid in this block (a commit)
         // overrides this handshake clear on the same edge.
         if (rx.frame_valid && rx.frame_ready)
            rx.frame_valid <= 1'b0;

         case (state)
            IDLE: if (cs) state <= SHIFT;
            SHIFT: begin
               if (cs) begin
                  if (full_len) begin
                     err_long <= 1'b1;
                     state    <= DRAIN;
                  end
               end else begin
                  state <= IDLE;
                  if (!full_len) begin
                     err_short <= 1'b1;
                  end else if (!rx.frame_valid || rx.frame_ready) begin
                     rx.frame_data  <= sh_data;
                     rx.frame_valid <= 1'b1;
                     frame_count    <= frame_count + 8'd1;
                  end else begin
                     err_overrun <= 1'b1;
                  end
               end
            end
            DRAIN: if (!cs) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sfsm_frame_rx.sv
// Randomised and directed bench for sfsm_frame_rx against a frame-level reference model.
module tb_sfsm_frame_rx;
   import sfsm_pkg::*;

   localparam int FB = SFSM_FRAME_BITS;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cs = 1'b0;
   logic       dout = 1'b0;
   logic       err_short, err_long, err_overrun;
   logic [7:0] frame_count;

   sfsm_frame_rx_if #(.FRAME_BITS(FB)) rx_if ();

   sfsm_frame_rx #(.FRAME_BITS(FB), .CNT_W(6)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cs          (cs),
      .dout        (dout),
      .rx          (rx_if),
      .err_short   (err_short),
      .err_long    (err_long),
      .err_overrun (err_overrun),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_short_seen = 0, n_long_seen = 0, n_ovr_seen = 0;

   // Reference model: tracks the length of the current cs-high run and its bits.
   int          run_len;
   logic        bits_q[$];
   logic [FB-1:0] m_data;
   logic        m_valid;
   logic [7:0]  m_count;
   logic        m_short, m_long, m_ovr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   task automatic m_reset();
      run_len = 0;
      bits_q.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_count = 8'd0;
      m_short = 1'b0;
      m_long  = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic m_update(input logic c, input logic d, input logic r);
      logic          was_valid;
      logic [FB-1:0] frame;
      was_valid = m_valid;
      m_short = 1'b0;
      m_long  = 1'b0;
      m_ovr   = 1'b0;
      if (was_valid && r) m_valid = 1'b0;
      if (c) begin
         run_len++;
         if (run_len <= FB) bits_q.push_back(d);
         if (run_len == FB + 1) m_long = 1'b1;
      end else begin
         if (run_len == FB) begin
            frame = '0;
            foreach (bits_q[i]) frame = {frame[FB-2:0], bits_q[i]};
            if (!was_valid || r) begin
               m_data  = frame;
               m_valid = 1'b1;
               m_count = m_count + 8'd1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (run_len >= 1 && run_len < FB) begin
            m_short = 1'b1;
         end
         run_len = 0;
         bits_q.delete();
      end
   endtask

   task automatic check_all();
      check("frame_data",  64'(rx_if.frame_data),  64'(m_data));
      check("frame_valid", 64'(rx_if.frame_valid), 64'(m_valid));
      check("err_short",   64'(err_short),   64'(m_short));
      check("err_long",    64'(err_long),    64'(m_long));
      check("err_overrun", 64'(err_overrun), 64'(m_ovr));
      check("frame_count", 64'(frame_count), 64'(m_count));
      if (err_short)   n_short_seen++;
      if (err_long)    n_long_seen++;
      if (err_overrun) n_ovr_seen++;
   endtask

   // One clock: drive at the falling edge, update the model at the rising edge, check after.
   task automatic step(input logic c, input logic d, input logic r);
      cs = c;
      dout = d;
      rx_if.frame_ready = r;
      @(posedge clk);
      if (!reset_n) m_reset();
      else m_update(c, d, r);
      @(negedge clk);
      check_all();
   endtask

   function automatic logic pick(input int mode);
      return (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
   endfunction

   // Sends len bits MSB first (random bits beyond 64), then gap low cycles.
   task automatic send_frame(input logic [63:0] val, input int len, input int gap,
                             input int r_bits, input int r_gap);
      for (int i = 0; i < len; i++)
         step(1'b1, (len <= 64) ? val[len-1-i] : 1'($urandom_range(0, 1)), pick(r_bits));
      for (int i = 0; i < gap; i++)
         step(1'b0, 1'b0, pick(r_gap));
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, r);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      m_reset();
      check_all();
      idle(2, 1'b0);
      reset_n = 1'b1;
   endtask

   int s0, l0, o0;
   logic [FB-1:0] fa, fb_val;

   initial begin
      rx_if.frame_ready = 1'b0;
      m_reset();
      #1;
      check_all();
      @(negedge clk);
      do_reset();

      // Legal frame: valid two edges after the last bit, no errors.
      s0 = n_short_seen; l0 = n_long_seen; o0 = n_ovr_seen;
      send_frame(64'h1_2345_6789, FB, 1, 0, 0);
      check("legal_data",  64'(rx_if.frame_data), 64'h1_2345_6789);
      check("legal_valid", 64'(rx_if.frame_valid), 64'd1);
      check("legal_count", 64'(frame_count), 64'd1);
      check("legal_noerr", 64'(n_short_seen + n_long_seen + n_ovr_seen - s0 - l0 - o0), 64'd0);
      idle(2, 1'b1);

      // Short frame of 20 bits.
      s0 = n_short_seen;
      send_frame(64'(32'hABCDE), 20, 3, 0, 0);
      check("short_pulses", 64'(n_short_seen - s0), 64'd1);
      check("short_valid",  64'(rx_if.frame_valid), 64'd0);
      check("short_count",  64'(frame_count), 64'd1);

      // Over-long frame of 40 cycles, then a normal frame.
      l0 = n_long_seen;
      send_frame(64'h0, 40, 2, 0, 0);
      check("long_pulses", 64'(n_long_seen - l0), 64'd1);
      check("long_count",  64'(frame_count), 64'd1);
      send_frame(64'h0_F0F0_1234, FB, 1, 0, 0);
      check("after_long_data",  64'(rx_if.frame_data), 64'h0_F0F0_1234);
      check("after_long_count", 64'(frame_count), 64'd2);
      idle(2, 1'b1);

      // Back-to-back frames with the consumer stalled: first is held, one overrun.
      o0 = n_ovr_seen;
      fa = 33'h1_5555_AAAA; fb_val = 33'h0_3333_CCCC;
      send_frame(64'(fa), FB, 1, 0, 0);
      send_frame(64'(fb_val), FB, 3, 0, 0);
      check("ovr_data",   64'(rx_if.frame_data), 64'(fa));
      check("ovr_pulses", 64'(n_ovr_seen - o0), 64'd1);
      check("ovr_count",  64'(frame_count), 64'd3);
      idle(2, 1'b1);

      // Ready raised on the second commit edge: second frame replaces the first.
      o0 = n_ovr_seen;
      send_frame(64'(fa), FB, 1, 0, 0);
      send_frame(64'(fb_val), FB, 1, 0, 1);
      idle(1, 1'b0);
      check("swap_data",   64'(rx_if.frame_data), 64'(fb_val));
      check("swap_valid",  64'(rx_if.frame_valid), 64'd1);
      check("swap_noovr",  64'(n_ovr_seen - o0), 64'd0);
      idle(2, 1'b1);

      // Reset asserted at bit 15 of a frame.
      for (int i = 0; i < 15; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      reset_n = 1'b0;
      #1;
      check("rst_valid", 64'(rx_if.frame_valid), 64'd0);
      check("rst_count", 64'(frame_count), 64'd0);
      check("rst_data",  64'(rx_if.frame_data), 64'd0);
      m_reset();
      idle(2, 1'b0);
      reset_n = 1'b1;
      send_frame(64'h1_0000_0001, FB, 1, 0, 0);
      check("post_rst_count", 64'(frame_count), 64'd1);
      idle(2, 1'b1);

      // 256 consumed frames wrap the counter back to zero.
      @(negedge clk);
      do_reset();
      for (int f = 0; f < 256; f++)
         send_frame({$urandom, $urandom}, FB, 1, 1, 1);
      idle(2, 1'b1);
      check("wrap_count", 64'(frame_count), 64'd0);

      // Randomised mix of legal, short and long frames with random back-pressure.
      for (int f = 0; f < 80; f++) begin
         int kind, len;
         kind = $urandom_range(0, 3);
         if (kind <= 1)      len = FB;
         else if (kind == 2) len = $urandom_range(1, FB - 1);
         else                len = $urandom_range(FB + 1, FB + 8);
         send_frame({$urandom, $urandom}, len, $urandom_range(1, 3), 2, 2);
      end
      idle(3, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sfsm_frame_rx.md
# sfsm_frame_rx

Host-side receiver for the SFSM serial link: deserializes the chip's `cs`-framed `dout` stream back into parallel frames. It tracks each frame with a state machine, checks its length, and buffers one completed frame behind a valid/ready handshake. It sits on the board/FPGA side of the link and shares a single clock with the transmitter, so there is no CDC logic.

## Interface
Parameters:
- `FRAME_BITS`, default 33: exact number of bits in a legal frame.
- `CNT_W`, default 6: bit-counter width; must satisfy 2^CNT_W > FRAME_BITS.

Ports:
- Clock/reset: one clock; reset is asynchronous and active-low.
- `clk` input 1: the single clock, the same clock that drives the transmitter; all sampling on its rising edge.
- `reset_n` input 1: asynchronous assert, synchronous deassert is the integrator's job.
- `cs` input 1: frame envelope, active high, driven by the transmitter's register.
- `dout` input 1: serial data, MSB first, one bit per `clk` while `cs` is high.
- `frame_data` output FRAME_BITS: the last accepted frame; bit FRAME_BITS-1 is the first bit received.
- `frame_valid` output 1: `frame_data` holds an unconsumed frame.
- `frame_ready` input 1: consumer accepts the frame when `frame_valid && frame_ready` at a rising edge.
- `err_short` output 1: one-cycle pulse when a frame ended with between 1 and FRAME_BITS-1 bits.
- `err_long` output 1: one-cycle pulse when `cs` stayed high for bit FRAME_BITS+1.
- `err_overrun` output 1: one-cycle pulse when a good frame was dropped because the buffer was full.
- `frame_count` output 8: count of accepted good frames; wraps from 255 to 0.

## Operation
- States:
  - IDLE: `cs` low.
  - SHIFT: collecting bits.
  - DRAIN: discarding an over-long frame.
- IDLE → SHIFT when `cs` is sampled high; that same edge captures bit 0 and sets the counter to 1.
- SHIFT, `cs` high, counter < FRAME_BITS: shift `dout` in and increment the counter.
- SHIFT, `cs` high, counter == FRAME_BITS: pulse `err_long`, go to DRAIN, discard the shift contents.
- SHIFT, `cs` low, counter == FRAME_BITS: commit the frame and go to IDLE.
- SHIFT, `cs` low, counter < FRAME_BITS: pulse `err_short`, go to IDLE, nothing is committed.
- DRAIN: stay while `cs` is high; go to IDLE on `cs` low. No further error pulses for the same frame.
- Commit rules:
  - Buffer empty, or `frame_valid && frame_ready` on the same edge: load `frame_data`, hold `frame_valid` high, increment `frame_count`.
  - Otherwise: keep the old frame, pulse `err_overrun`, leave `frame_count` unchanged.
- Handshake: `frame_valid` falls on the edge after a handshake unless a commit reloads the buffer on that same edge. `frame_data` is stable while `frame_valid` is high.
- Back-to-back frames: `cs` low for exactly one cycle between frames is legal. The low cycle commits the previous frame, and the next high sample starts the new one.
- The counter never exceeds FRAME_BITS, so there is no wrap inside the counter.

## Timing
- Reset values:
  - state = IDLE.
  - `frame_data` = 0.
  - `frame_valid` = 0.
  - `err_short`, `err_long`, `err_overrun` = 0.
  - `frame_count` = 0.
  - Shift register and counter = 0.
- Reset mid-frame: the partial frame is lost. After reset is released while `cs` is high, the block treats that as a new frame start; the transmitter is reset together with this block, so this case is benign.
- Latency: last data bit sampled at edge N, `cs` low sampled at N+1, `frame_valid` high after N+1 (2 cycles from the last bit).
- Error pulses are registered; each is high for exactly the cycle after its detecting edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `sfsm_pkg` holds:
  - The state enum `rx_state_t` (IDLE, SHIFT, DRAIN).
  - The constant `SFSM_FRAME_BITS` = 33, shared with the transmitter.
- One sub-module, `sfsm_rx_shifter`, contains the shift register and bit counter, with `clear`/`shift_en` controls and a `count` output.
- The top-level module holds the FSM, the output buffer, the error flags and `frame_count`.

## Test plan
- Legal frame 33'h1_2345_6789, then `cs` low, `frame_ready`=1 → `frame_data`=33'h1_2345_6789 and `frame_valid` high 2 cycles after the last bit. `frame_count`=1 and no error pulses.
- `cs` high for 20 bits then low → one `err_short` pulse, `frame_valid` stays 0, `frame_count` unchanged.
- `cs` high for 40 cycles → one `err_long` pulse at the 34th sample, no commit. A following legal frame is accepted normally.
- Two back-to-back legal frames (one-cycle `cs` gap), `frame_ready`=0 → the first frame is held and `err_overrun` pulses once. Raising `frame_ready` on the second commit edge instead loads the second frame with no overrun.
- Assert `reset_n` low mid-frame at bit 15 → all outputs return to their reset values immediately. The next legal frame is accepted with `frame_count`=1.
- 256 legal frames, each consumed → `frame_count` wraps to 0.
